result_to_digits: RTL

Output-side counterpart of the keypad input handler. It takes a signed two's-complement result from the calculator datapath and converts it iteratively (shift-and-add-3) into five BCD digits plus a sign flag, in the same digit/sign format the keypad path produces, ready for `dec_to_7seg` / `sign_to_7seg`. It sits between the arithmetic core and the HEX display drivers, with a start/busy/done handshake toward the core.

---
 rtl/calc_pkg.sv | 25 ++
 rtl/dabble_step.sv | 14 +
 rtl/result_to_digits.sv | 110 +++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared calculator constants, BCD codes and the result_to_digits FSM state type.
package calc_pkg;

   localparam int DIGITS = 5;
   localparam logic [3:0] BCD_ERR   = 4'hE;
   localparam logic [3:0] BCD_BLANK = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ABS   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } r2d_state_t;

   // Largest magnitude representable in n decimal digits: 10^n - 1.
   function automatic longint unsigned max_for_digits(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p - 64'd1;
   endfunction

   localparam longint unsigned MAX_DISPLAY = max_for_digits(DIGITS);

endpackage

// File: rtl/dabble_step.sv
// Combinational add-3 correction applied to every BCD nibble before a shift.
module dabble_step #(
   parameter int DIGITS = calc_pkg::DIGITS
) (
   input  logic [DIGITS*4-1:0] bcd_in,
   output logic [DIGITS*4-1:0] bcd_out
);

   for (genvar i = 0; i < DIGITS; i++) begin : g_nib
      assign bcd_out[i*4 +: 4] = (bcd_in[i*4 +: 4] >= 4'd5) ? bcd_in[i*4 +: 4] + 4'd3
                                                             : bcd_in[i*4 +: 4];
   end

endmodule

// File: rtl/result_to_digits.sv
// Signed result to BCD digits + sign via iterative shift-and-add-3.
// Optional BLANK_LEADING_ZEROS_EN replaces leading zero digits with blanks.
module result_to_digits
   import calc_pkg::*;
#(
   parameter int WIDTH  = 18,
   parameter int DIGITS = calc_pkg::DIGITS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [WIDTH-1:0]    value,
   output logic                busy,
   output logic                done,
   output logic [DIGITS*4-1:0] digits,
   output logic                plus,
   output logic                overflow,
   output r2d_state_t          dbg_state
);

   localparam int DW = DIGITS * 4;
   localparam int CW = $clog2(WIDTH + 1);
   localparam longint unsigned MAX_MAG = max_for_digits(DIGITS);

   r2d_state_t       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
   logic [DW-1:0]    bcd;
   logic             neg_r;
   logic             ovf_r;

   logic [WIDTH-1:0] abs_val;
   logic [DW-1:0]    dab_out;
   logic [DW-1:0]    final_digits;

   // shreg holds the raw captured value until ABS rewrites it with the magnitude.
   assign abs_val   = shreg[WIDTH-1] ? (~shreg + 1'b1) : shreg;
   assign dbg_state = state;

   dabble_step #(.DIGITS(DIGITS)) u_dabble (
      .bcd_in  (bcd),
      .bcd_out (dab_out)
   );

`ifdef BLANK_LEADING_ZEROS_EN
   logic lead;
   always_comb begin
      final_digits = bcd;
      lead         = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && (bcd[i*4 +: 4] == 4'd0)) final_digits[i*4 +: 4] = BCD_BLANK;
         else                                 lead = 1'b0;
      end
   end
`else
   assign final_digits = bcd;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         shreg    <= '0;
         bcd      <= '0;
         neg_r    <= 1'b0;
         ovf_r    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         digits   <= '0;
         plus     <= 1'b1;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shreg <= value;
                  busy  <= 1'b1;
                  state <= ABS;
               end
            end
            ABS: begin
               neg_r <= shreg[WIDTH-1];
               shreg <= abs_val;
               ovf_r <= 64'(abs_val) > MAX_MAG;
               bcd   <= '0;
               cnt   <= CW'(WIDTH);
               state <= SHIFT;
            end
            SHIFT: begin
               // Bits leaving the top of the accumulator only matter on overflow.
               bcd   <= {dab_out[DW-2:0], shreg[WIDTH-1]};
               shreg <= {shreg[WIDTH-2:0], 1'b0};
               cnt   <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= DONE;
            end
            DONE: begin
               digits   <= ovf_r ? {DIGITS{BCD_ERR}} : final_digits;
               plus     <= ~neg_r;
               overflow <= ovf_r;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
